// File: rtl/cmd_decoder.sv
// Command decoder: turns received 8-byte frames into memory writes/reads and
// sends one response frame per accepted command back through the UART source.
module cmd_decoder #(
  parameter int TIMEOUT = 255
) (
  input  logic        iCLOCK,
  input  logic        iNRESET,
  input  logic        iDONE,
  input  logic [63:0] iFDATA,
  output logic        oMEM_WE,
  output logic        oMEM_RE,
  output logic [15:0] oMEM_ADDR,
  output logic [31:0] oMEM_WDATA,
  input  logic [31:0] iMEM_RDATA,
  input  logic        iMEM_VALID,
  output logic        oTX_START,
  output logic [63:0] oTX_DATA,
  input  logic        iTX_BUSY,
  output logic        oBUSY,
  output logic [7:0]  oDROPCNT,
  output logic [2:0]  oDBG_STATE
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_MEMWR  = 3'd2,
    S_MEMRD  = 3'd3,
    S_RESP   = 3'd4,
    S_TXWAIT = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   frame_q, frame_d;
  logic [63:0]   resp_q, resp_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic          re_first_q, re_first_d;
  logic          seen_q, seen_d;
  logic [7:0]    drop_q, drop_d;

  logic          accept;
  logic          mem_we;
  logic          mem_re;
  logic          tx_start;
  logic [15:0]   f_op;
  logic [15:0]   f_addr;
  logic [31:0]   f_data;

  assign f_op   = frame_q[63:48];
  assign f_addr = frame_q[47:32];
  assign f_data = frame_q[31:0];

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    resp_d     = resp_q;
    tmo_d      = tmo_q;
    re_first_d = 1'b0;
    seen_d     = seen_q;
    drop_d     = drop_q;
    accept     = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    tx_start   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (iDONE) accept = 1'b1;
      end
      S_DECODE: begin
        case (f_op)
          16'h0001: begin
            state_d = S_MEMWR;
            resp_d  = {f_op | 16'h8000, f_addr, f_data};
          end
          16'h0002: begin
            state_d    = S_MEMRD;
            re_first_d = 1'b1;
            tmo_d      = '0;
          end
          16'h0000: begin
            state_d = S_RESP;
            resp_d  = {f_op | 16'h8000, f_addr, f_data};
          end
          default: begin
            state_d = S_RESP;
            resp_d  = {16'hFFFF, f_addr, 32'h0};
          end
        endcase
      end
      S_MEMWR: begin
        mem_we  = 1'b1;
        state_d = S_RESP;
      end
      S_MEMRD: begin
        // First MEMRD cycle issues the strobe; valid is only sampled afterwards.
        if (re_first_q) begin
          mem_re = 1'b1;
        end else if (iMEM_VALID) begin
          resp_d  = {f_op | 16'h8000, f_addr, iMEM_RDATA};
          state_d = S_RESP;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          resp_d  = {16'hFFFE, f_addr, 32'h0};
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        if (!iTX_BUSY) begin
          tx_start = 1'b1;
          seen_d   = 1'b0;
          state_d  = S_TXWAIT;
        end
      end
      S_TXWAIT: begin
        if (iTX_BUSY) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          state_d = S_IDLE;
          if (iDONE) accept = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A frame arriving on the TXWAIT->IDLE transition is taken, not dropped.
    if (accept) begin
      frame_d = iFDATA;
      state_d = S_DECODE;
    end else if (iDONE) begin
      drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
    end
  end

  always_ff @(posedge iCLOCK or negedge iNRESET) begin
    if (!iNRESET) begin
      state_q    <= S_IDLE;
      frame_q    <= '0;
      resp_q     <= '0;
      tmo_q      <= '0;
      re_first_q <= 1'b0;
      seen_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      frame_q    <= frame_d;
      resp_q     <= resp_d;
      tmo_q      <= tmo_d;
      re_first_q <= re_first_d;
      seen_q     <= seen_d;
      drop_q     <= drop_d;
    end
  end

  assign oMEM_WE    = mem_we;
  assign oMEM_RE    = mem_re;
  assign oMEM_ADDR  = f_addr;
  assign oMEM_WDATA = f_data;
  assign oTX_START  = tx_start;
  assign oTX_DATA   = resp_q;
  assign oBUSY      = (state_q != S_IDLE);
  assign oDROPCNT   = drop_q;
  assign oDBG_STATE = state_q;

endmodule

// File: tb/tb_cmd_decoder.sv
// Bench for cmd_decoder: timeline reference model of each transaction, a
// memory/UART responder, directed scenarios and a randomized phase.
module tb_cmd_decoder;

  localparam int T = 20;

  logic        clk = 1'b0;
  logic        iNRESET;
  logic        iDONE;
  logic [63:0] iFDATA;
  logic        oMEM_WE;
  logic        oMEM_RE;
  logic [15:0] oMEM_ADDR;
  logic [31:0] oMEM_WDATA;
  logic [31:0] iMEM_RDATA;
  logic        iMEM_VALID;
  logic        oTX_START;
  logic [63:0] oTX_DATA;
  logic        iTX_BUSY;
  logic        oBUSY;
  logic [7:0]  oDROPCNT;
  logic [2:0]  dbg_state;

  cmd_decoder #(.TIMEOUT(T)) dut (
    .iCLOCK(clk), .iNRESET(iNRESET), .iDONE(iDONE), .iFDATA(iFDATA),
    .oMEM_WE(oMEM_WE), .oMEM_RE(oMEM_RE), .oMEM_ADDR(oMEM_ADDR),
    .oMEM_WDATA(oMEM_WDATA), .iMEM_RDATA(iMEM_RDATA), .iMEM_VALID(iMEM_VALID),
    .oTX_START(oTX_START), .oTX_DATA(oTX_DATA), .iTX_BUSY(iTX_BUSY),
    .oBUSY(oBUSY), .oDROPCNT(oDROPCNT), .oDBG_STATE(dbg_state)
  );

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- responder (memory + UART source) ----------------
  int          rd_delay = 3;      // 0 means the memory never answers
  logic [31:0] rd_val   = 32'h0;
  int          tx_len   = 3;
  bit          ext_busy = 1'b0;

  int          mem_tgt    = -1;
  logic [31:0] mem_val    = 32'h0;
  int          busy_from  = 0;
  int          busy_until = -1;
  int          we_cnt = 0, re_cnt = 0, tx_cnt = 0;
  logic [15:0] we_addr = 16'h0;
  logic [31:0] we_data = 32'h0;
  logic [63:0] last_tx = 64'h0;
  int          re_cyc = 0, start_cyc = 0;

  initial begin
    iMEM_VALID = 1'b0;
    iMEM_RDATA = 32'h0;
    iTX_BUSY   = 1'b0;
    forever begin
      @(negedge clk);
      if (iNRESET) begin
        if (oMEM_RE) begin
          mem_tgt = (rd_delay > 0) ? cyc + rd_delay : -1;
          mem_val = rd_val;
          re_cnt++;
          re_cyc = cyc;
        end
        if (oMEM_WE) begin
          we_cnt++;
          we_addr = oMEM_ADDR;
          we_data = oMEM_WDATA;
        end
        if (oTX_START) begin
          tx_cnt++;
          last_tx    = oTX_DATA;
          start_cyc  = cyc;
          busy_from  = cyc + 1;
          busy_until = cyc + tx_len;
        end
      end
      @(posedge clk);
      #1;
      if (!iNRESET) begin
        mem_tgt    = -1;
        busy_until = -1;
      end
      iMEM_VALID = (cyc == mem_tgt);
      iMEM_RDATA = iMEM_VALID ? mem_val : $urandom;
      iTX_BUSY   = ext_busy || (cyc >= busy_from && cyc <= busy_until);
    end
  end

  // ---------------- reference model + scoreboard ----------------
  logic [63:0] exp_q[$];
  bit          m_fl = 1'b0;
  int          m_acc = 0;
  int          m_kind = 0;        // 0 ping, 1 write, 2 read, 3 unknown
  logic [15:0] m_op, m_addr;
  logic [31:0] m_data;
  bit          m_known = 1'b0;
  int          m_resp_cyc = 0;
  logic [63:0] m_resp = 64'h0;
  bit          m_started = 1'b0;
  int          m_start = 0;
  bit          m_seen = 1'b0;
  int          m_drops = 0;
  bit          e_we, e_re, e_start, ending;
  int          c;

  always @(negedge clk) begin
    c = cyc;
    if (!iNRESET) begin
      check("reset_ctrl", 64'({oMEM_WE, oMEM_RE, oTX_START, oBUSY, oDROPCNT}), 64'h0);
      check("reset_data", 64'({oMEM_ADDR, oMEM_WDATA}) | oTX_DATA, 64'h0);
      m_fl = 1'b0;
      m_drops = 0;
      exp_q.delete();
    end else begin
      e_we    = m_fl && m_kind == 1 && c == m_acc + 2;
      e_re    = m_fl && m_kind == 2 && c == m_acc + 2;
      e_start = m_fl && m_known && !m_started && c >= m_resp_cyc && !iTX_BUSY;
      check("mem_we", 64'(oMEM_WE), 64'(e_we));
      check("mem_re", 64'(oMEM_RE), 64'(e_re));
      check("tx_start", 64'(oTX_START), 64'(e_start));
      check("busy", 64'(oBUSY), 64'(m_fl && c > m_acc));
      check("dropcnt", 64'(oDROPCNT), 64'(m_drops));
      if (e_we || e_re) check("mem_addr", 64'(oMEM_ADDR), 64'(m_addr));
      if (e_we) check("mem_wdata", 64'(oMEM_WDATA), 64'(m_data));
      if (m_fl && (e_start || m_started)) check("tx_data_hold", oTX_DATA, m_resp);
      if (oTX_START) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_frame: start with data %h, required no start", oTX_DATA);
        end else begin
          check("tx_frame", oTX_DATA, exp_q.pop_front());
        end
      end

      ending = 1'b0;
      if (m_fl && m_kind == 2 && !m_known && c >= m_acc + 3) begin
        if (iMEM_VALID) begin
          m_resp = {m_op | 16'h8000, m_addr, iMEM_RDATA};
          m_known = 1'b1;
          m_resp_cyc = c + 1;
          exp_q.push_back(m_resp);
        end else if (c == m_acc + 2 + T) begin
          m_resp = {16'hFFFE, m_addr, 32'h0};
          m_known = 1'b1;
          m_resp_cyc = c + 1;
          exp_q.push_back(m_resp);
        end
      end
      if (e_start) begin
        m_started = 1'b1;
        m_start = c;
      end else if (m_fl && m_started && c > m_start) begin
        if (iTX_BUSY) m_seen = 1'b1;
        else if (m_seen) ending = 1'b1;
      end
      if (ending) m_fl = 1'b0;

      if (iDONE) begin
        if (!m_fl) begin
          m_fl = 1'b1;
          m_acc = c;
          m_op = iFDATA[63:48];
          m_addr = iFDATA[47:32];
          m_data = iFDATA[31:0];
          m_started = 1'b0;
          m_seen = 1'b0;
          m_known = 1'b1;
          case (m_op)
            16'h0000: begin m_kind = 0; m_resp_cyc = c + 2; m_resp = {m_op | 16'h8000, m_addr, m_data}; end
            16'h0001: begin m_kind = 1; m_resp_cyc = c + 3; m_resp = {m_op | 16'h8000, m_addr, m_data}; end
            16'h0002: begin m_kind = 2; m_known = 1'b0; end
            default:  begin m_kind = 3; m_resp_cyc = c + 2; m_resp = {16'hFFFF, m_addr, 32'h0}; end
          endcase
          if (m_known) exp_q.push_back(m_resp);
        end else if (m_drops < 255) begin
          m_drops++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [63:0] f);
    iDONE  = 1'b1;
    iFDATA = f;
    tick();
    iDONE  = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      @(negedge clk);
      if (!oBUSY) done = 1'b1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL wait_idle: busy still 1 after 2000 cycles, required 0");
    end
    tick();
  endtask

  // ---------------- stimulus ----------------
  int          we0, re0, tx0, d0;
  int          lim;
  logic [15:0] r_op;
  logic [63:0] r_frame;

  initial begin
    iNRESET = 1'b0;
    iDONE   = 1'b0;
    iFDATA  = 64'h0;
    repeat (3) tick();
    iNRESET = 1'b1;
    tick();

    // write
    send(64'h0001_0010_DEADBEEF);
    wait_idle();
    check("wr_resp", last_tx, 64'h8001_0010_DEADBEEF);
    check("wr_addr", 64'(we_addr), 64'h0010);
    check("wr_data", 64'(we_data), 64'hDEADBEEF);
    check("wr_count", 64'(we_cnt), 64'd1);

    // read answered three cycles after the strobe
    rd_delay = 3;
    rd_val   = 32'h12345678;
    send(64'h0002_0010_00000000);
    wait_idle();
    check("rd_resp", last_tx, 64'h8002_0010_12345678);
    check("rd_count", 64'(re_cnt), 64'd1);

    // read timeout
    rd_delay = 0;
    send(64'h0002_0010_00000000);
    wait_idle();
    check("tmo_resp", last_tx, 64'hFFFE_0010_00000000);
    check("tmo_latency", 64'(start_cyc - re_cyc), 64'(T + 1));

    // valid arriving after the timeout is ignored
    rd_delay = T + 2;
    rd_val   = 32'h0BAD_0BAD;
    send(64'h0002_0020_00000000);
    wait_idle();
    check("late_valid_resp", last_tx, 64'hFFFE_0020_00000000);

    // unknown opcode
    we0 = we_cnt;
    re0 = re_cnt;
    send(64'h00AA_1234_55555555);
    wait_idle();
    check("unk_resp", last_tx, 64'hFFFF_1234_00000000);
    check("unk_no_strobe", 64'((we_cnt - we0) + (re_cnt - re0)), 64'd0);

    // ping
    send(64'h0000_ABCD_CAFEF00D);
    wait_idle();
    check("ping_resp", last_tx, 64'h8000_ABCD_CAFEF00D);

    // three frames arriving during one read
    rd_delay = 10;
    rd_val   = 32'h00C0FFEE;
    tx0 = tx_cnt;
    send(64'h0002_0030_00000000);
    for (int i = 0; i < 3; i++) begin
      send(64'h0001_0099_11111111);
      tick();
    end
    wait_idle();
    check("overrun_drops", 64'(oDROPCNT), 64'd3);
    check("overrun_one_resp", 64'(tx_cnt - tx0), 64'd1);
    check("overrun_resp", last_tx, 64'h8002_0030_00C0FFEE);

    // frame arriving on the cycle TXWAIT returns to IDLE is accepted
    tx_len = 2;
    d0 = oDROPCNT;
    tx0 = tx_cnt;
    send(64'h0000_0001_00000001);
    lim = 0;
    while (tx_cnt == tx0 && lim < 200) begin tick(); lim++; end
    lim = 0;
    while (cyc != busy_until + 1 && lim < 200) begin tick(); lim++; end
    send(64'h0001_0055_77777777);
    wait_idle();
    check("b2b_drops", 64'(oDROPCNT), 64'(d0));
    check("b2b_resp_count", 64'(tx_cnt - tx0), 64'd2);
    check("b2b_resp", last_tx, 64'h8001_0055_77777777);

    // saturation: 300 frames while the response is held off by a busy sink
    ext_busy = 1'b1;
    tick();
    tick();
    send(64'h0000_0002_00000002);
    repeat (300) begin
      iDONE  = 1'b1;
      iFDATA = {$urandom, $urandom};
      tick();
    end
    iDONE = 1'b0;
    ext_busy = 1'b0;
    wait_idle();
    check("drop_saturate", 64'(oDROPCNT), 64'd255);

    // reset while waiting in MEMRD, then a write on the first clock after release
    rd_delay = 0;
    send(64'h0002_0040_00000000);
    repeat (5) tick();
    tx0 = tx_cnt;
    we0 = we_cnt;
    iNRESET = 1'b0;
    repeat (3) tick();
    check("rst_no_start", 64'(tx_cnt - tx0), 64'd0);
    iNRESET = 1'b1;
    send(64'h0001_0044_A5A5A5A5);
    wait_idle();
    check("post_rst_resp", last_tx, 64'h8001_0044_A5A5A5A5);
    check("post_rst_we", 64'(we_cnt - we0), 64'd1);
    check("post_rst_drops", 64'(oDROPCNT), 64'd0);

    // randomized traffic with a reset halfway through
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        iDONE = 1'b0;
        iNRESET = 1'b0;
        tick();
        tick();
        iNRESET = 1'b1;
      end
      case ($urandom_range(0, 3))
        0: r_op = 16'h0000;
        1: r_op = 16'h0001;
        2: r_op = 16'h0002;
        default: r_op = 16'($urandom_range(3, 16'hFFFF));
      endcase
      r_frame  = {r_op, 16'($urandom), $urandom};
      iDONE    = ($urandom_range(0, 24) == 0);
      iFDATA   = r_frame;
      rd_delay = $urandom_range(0, T + 4);
      rd_val   = $urandom;
      tx_len   = $urandom_range(1, 4);
      if ($urandom_range(0, 49) == 0) ext_busy = ~ext_busy;
      tick();
    end
    iDONE = 1'b0;
    ext_busy = 1'b0;
    wait_idle();
    check("no_pending_resp", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
